// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_pkg
// Description : Shared definitions for the NPC core sequencer and decoders.
//               RV32 opcode constants, the ebreak encoding, and the enums for
//               sequencer state, halt reason and instruction class.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_pkg;

    localparam logic [6:0]  OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD    = 7'b0000011;
    localparam logic [6:0]  OPC_STORE   = 7'b0100011;
    localparam logic [31:0] INST_EBREAK = 32'h00100073;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_IWAIT  = 3'd1,
        S_DECODE = 3'd2,
        S_MREQ   = 3'd3,
        S_MWAIT  = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } seq_state_t;

    // Encoding is visible on the halt_code port, so values are fixed.
    typedef enum logic [1:0] {
        HC_NONE    = 2'b00,
        HC_EBREAK  = 2'b01,
        HC_ILLEGAL = 2'b10,
        HC_TIMEOUT = 2'b11
    } halt_code_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_OPIMM   = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_EBREAK  = 3'd4
    } inst_class_t;

endpackage : npc_pkg
`default_nettype wire

// File: rtl/npc_inst_class.sv
`default_nettype none
// ============================================================================
// Module      : npc_inst_class
// Description : Purely combinational instruction classifier. Maps a 32-bit
//               instruction word to an inst_class_t.
// Ports       : inst       in  32  instruction word
//               inst_class out  3   class (OP-IMM/LOAD/STORE/EBREAK/ILLEGAL)
// Revision    : 1.0 - initial release
// ============================================================================
module npc_inst_class
    import npc_pkg::*;
(
    input  logic [31:0] inst,
    output inst_class_t inst_class
);

    always_comb begin
        inst_class = CLS_ILLEGAL;
        // ebreak shares the SYSTEM opcode with other encodings, so it needs
        // a full-word match and must take priority over the opcode decode.
        if (inst == INST_EBREAK) begin
            inst_class = CLS_EBREAK;
        end else begin
            case (inst[6:0])
                OPC_OPIMM: inst_class = CLS_OPIMM;
                OPC_LOAD:  inst_class = CLS_LOAD;
                OPC_STORE: inst_class = CLS_STORE;
                default:   inst_class = CLS_ILLEGAL;
            endcase
        end
    end

endmodule : npc_inst_class
`default_nettype wire

// File: rtl/npc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : npc_seq_ctrl
// Description : Multi-cycle sequencer for the NPC core. Fetches one
//               instruction over a valid/ready IFU interface, classifies it,
//               optionally performs one LSU transaction, then issues one-cycle
//               register-file / PC write strobes. Halts (sticky) on ebreak,
//               illegal opcode, or IFU/LSU response timeout.
// Ports       : clk, rst_n                      clock, async active-low reset
//               ifu_req_valid/ready             fetch request handshake
//               ifu_rsp_valid, ifu_rsp_inst     fetch response
//               inst_q                          latched current instruction
//               lsu_req_valid/we/ready          memory request handshake
//               lsu_rsp_valid                   load data / store ack
//               rf_we, pc_we                    write-back strobes
//               retired_cnt                     retired-instruction counter
//               halt, halt_code                 sticky halt flag and reason
// Revision    : 1.0 - initial release
// ============================================================================
module npc_seq_ctrl
    import npc_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    input  logic             ifu_rsp_valid,
    input  logic [31:0]      ifu_rsp_inst,
    output logic [31:0]      inst_q,
    output logic             lsu_req_valid,
    output logic             lsu_req_we,
    input  logic             lsu_req_ready,
    input  logic             lsu_rsp_valid,
    output logic             rf_we,
    output logic             pc_we,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             halt,
    output logic [1:0]       halt_code
);

    localparam int             TMO_W      = $clog2(TIMEOUT + 1);
    // The counter reads 0 in the first wait cycle, so the TIMEOUT-th wait
    // cycle is the one where it reads TIMEOUT-1.
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT - 1);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic [31:0]       r_inst_q;
    logic [CNT_W-1:0]  r_retired;
    halt_code_t        r_halt_code;
    halt_code_t        w_halt_code_nxt;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_run;
    logic              w_retire;
    logic              w_tmo_hit;
    inst_class_t       w_cls;

    npc_inst_class u_inst_class (
        .inst       (r_inst_q),
        .inst_class (w_cls)
    );

    assign w_tmo_hit = (r_tmo == c_tmo_last);

    always_comb begin
        w_next_state    = r_state;
        w_halt_code_nxt = r_halt_code;
        w_retire        = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (r_run && ifu_req_ready) w_next_state = S_IWAIT;
            end
            S_IWAIT: begin
                // A response in the expiry cycle still wins.
                if (ifu_rsp_valid) begin
                    w_next_state = S_DECODE;
                end else if (w_tmo_hit) begin
                    w_next_state    = S_HALT;
                    w_halt_code_nxt = HC_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (w_cls)
                    CLS_EBREAK: begin
                        w_next_state    = S_HALT;
                        w_halt_code_nxt = HC_EBREAK;
                        w_retire        = 1'b1;
                    end
                    CLS_OPIMM: w_next_state = S_WB;
                    CLS_LOAD,
                    CLS_STORE: w_next_state = S_MREQ;
                    default: begin
                        w_next_state    = S_HALT;
                        w_halt_code_nxt = HC_ILLEGAL;
                    end
                endcase
            end
            S_MREQ: begin
                if (lsu_req_ready) w_next_state = S_MWAIT;
            end
            S_MWAIT: begin
                if (lsu_rsp_valid) begin
                    w_next_state = S_WB;
                end else if (w_tmo_hit) begin
                    w_next_state    = S_HALT;
                    w_halt_code_nxt = HC_TIMEOUT;
                end
            end
            S_WB: begin
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_HALT: w_next_state = S_HALT;
            default: w_next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_inst_q    <= 32'h0;
            r_retired   <= '0;
            r_halt_code <= HC_NONE;
            r_tmo       <= '0;
            r_run       <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_halt_code <= w_halt_code_nxt;
            // Keeps the fetch request low while reset is held even though the
            // state already reads FETCH; rises on the first edge after release.
            r_run       <= 1'b1;
            if (r_state == S_IWAIT && ifu_rsp_valid) begin
                r_inst_q <= ifu_rsp_inst;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            // Wait states are only entered from FETCH/MREQ where the counter
            // is held at zero, so entry always starts a fresh count. The
            // state is left at c_tmo_last, so the counter cannot overflow.
            if (r_state == S_IWAIT || r_state == S_MWAIT) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end else begin
                r_tmo <= '0;
            end
        end
    end

    // All outputs decode from registered state only.
    assign ifu_req_valid = (r_state == S_FETCH) && r_run;
    assign lsu_req_valid = (r_state == S_MREQ);
    assign lsu_req_we    = (r_state == S_MREQ) && (w_cls == CLS_STORE);
    assign pc_we         = (r_state == S_WB);
    assign rf_we         = (r_state == S_WB) &&
                           ((w_cls == CLS_OPIMM) || (w_cls == CLS_LOAD));
    assign halt          = (r_state == S_HALT);
    assign halt_code     = r_halt_code;
    assign inst_q        = r_inst_q;
    assign retired_cnt   = r_retired;

endmodule : npc_seq_ctrl
`default_nettype wire

// File: tb/tb_npc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_npc_seq_ctrl
// Description : Directed self-checking bench for npc_seq_ctrl (CNT_W=4,
//               TIMEOUT=8). Inputs change and outputs are sampled 1 ns after
//               each rising clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_seq_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;

    localparam logic [31:0] c_addi   = 32'h00500093;
    localparam logic [31:0] c_lw     = 32'h0000A103;
    localparam logic [31:0] c_sw     = 32'h0020A023;
    localparam logic [31:0] c_ebreak = 32'h00100073;
    localparam logic [31:0] c_illeg  = 32'h0000007F;

    logic             clk;
    logic             rst_n;
    logic             ifu_req_valid;
    logic             ifu_req_ready;
    logic             ifu_rsp_valid;
    logic [31:0]      ifu_rsp_inst;
    logic [31:0]      inst_q;
    logic             lsu_req_valid;
    logic             lsu_req_we;
    logic             lsu_req_ready;
    logic             lsu_rsp_valid;
    logic             rf_we;
    logic             pc_we;
    logic [CNT_W-1:0] retired_cnt;
    logic             halt;
    logic [1:0]       halt_code;

    int n_tests = 0;
    int n_fail  = 0;
    int fetch_seen;

    npc_seq_ctrl #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_inst  (ifu_rsp_inst),
        .inst_q        (inst_q),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_we    (lsu_req_we),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .rf_we         (rf_we),
        .pc_we         (pc_we),
        .retired_cnt   (retired_cnt),
        .halt          (halt),
        .halt_code     (halt_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = 32'h0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
    endtask

    // Ends one cycle after release: first FETCH cycle with the request up.
    task automatic do_reset;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // From a FETCH cycle with request up; ends in the DECODE cycle.
    task automatic do_fetch(input logic [31:0] inst);
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = inst;
        tick();
        ifu_rsp_valid = 1'b0;
    endtask

    // One complete addi; ends in the next FETCH cycle.
    task automatic do_addi;
        do_fetch(c_addi);
        tick();
        tick();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_ifu_req_valid", ifu_req_valid, 0);
        chk("rst_inst_q",        inst_q,        0);
        chk("rst_retired",       retired_cnt,   0);
        chk("rst_halt",          halt,          0);
        chk("rst_halt_code",     halt_code,     0);
        chk("rst_lsu_req_valid", lsu_req_valid, 0);
        chk("rst_rf_we",         rf_we,         0);
        chk("rst_pc_we",         pc_we,         0);

        rst_n = 1'b1;
        tick();
        chk("first_fetch_valid", ifu_req_valid, 1);

        // addi: FETCH(1) IWAIT(2) DECODE(3) WB(4) FETCH(5)
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        chk("iwait_req_low", ifu_req_valid, 0);
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = c_addi;
        tick();
        ifu_rsp_valid = 1'b0;
        chk("addi_inst_q", inst_q, c_addi);
        tick();
        chk("addi_rf_we_c4", rf_we, 1);
        chk("addi_pc_we_c4", pc_we, 1);
        chk("addi_cnt_c4",   retired_cnt, 0);
        tick();
        chk("addi_fetch_c5", ifu_req_valid, 1);
        chk("addi_pc_we_c5", pc_we, 0);
        chk("addi_cnt_c5",   retired_cnt, 1);

        // lw: LSU ready after two MREQ cycles, response in third MWAIT cycle
        do_fetch(c_lw);
        tick();
        chk("lw_mreq_valid", lsu_req_valid, 1);
        chk("lw_mreq_we",    lsu_req_we, 0);
        tick();
        chk("lw_hold_valid", lsu_req_valid, 1);
        chk("lw_hold_we",    lsu_req_we, 0);
        lsu_req_ready = 1'b1;
        tick();
        lsu_req_ready = 1'b0;
        chk("lw_mwait_req_low", lsu_req_valid, 0);
        tick();
        tick();
        lsu_rsp_valid = 1'b1;
        tick();
        lsu_rsp_valid = 1'b0;
        chk("lw_wb_rf_we", rf_we, 1);
        chk("lw_wb_pc_we", pc_we, 1);
        tick();
        chk("lw_cnt", retired_cnt, 2);

        // sw
        do_fetch(c_sw);
        tick();
        chk("sw_mreq_valid", lsu_req_valid, 1);
        chk("sw_mreq_we",    lsu_req_we, 1);
        lsu_req_ready = 1'b1;
        tick();
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b1;
        tick();
        lsu_rsp_valid = 1'b0;
        chk("sw_wb_rf_we", rf_we, 0);
        chk("sw_wb_pc_we", pc_we, 1);
        tick();
        chk("sw_cnt", retired_cnt, 3);

        // ebreak after three addi
        do_reset();
        repeat (3) do_addi();
        do_fetch(c_ebreak);
        tick();
        chk("ebreak_halt",  halt, 1);
        chk("ebreak_code",  halt_code, 2'b01);
        chk("ebreak_cnt",   retired_cnt, 4);
        chk("ebreak_pc_we", pc_we, 0);
        ifu_req_ready = 1'b1;
        fetch_seen = 0;
        repeat (100) begin
            tick();
            if (ifu_req_valid) fetch_seen++;
        end
        ifu_req_ready = 1'b0;
        chk("halt_no_fetch",  fetch_seen, 0);
        chk("halt_code_hold", halt_code, 2'b01);

        // asynchronous reset while halted (no clock edge in between)
        rst_n = 1'b0;
        #1;
        chk("arst_halt_halt", halt, 0);
        chk("arst_halt_code", halt_code, 0);
        chk("arst_halt_cnt",  retired_cnt, 0);
        chk("arst_halt_instq", inst_q, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_halt_restart", ifu_req_valid, 1);

        // illegal opcode
        do_addi();
        do_fetch(c_illeg);
        tick();
        chk("illegal_halt",  halt, 1);
        chk("illegal_code",  halt_code, 2'b10);
        chk("illegal_cnt",   retired_cnt, 1);
        chk("illegal_pc_we", pc_we, 0);

        // LSU response withheld: halt after 8 MWAIT cycles
        do_reset();
        do_fetch(c_lw);
        tick();
        lsu_req_ready = 1'b1;
        tick();
        lsu_req_ready = 1'b0;
        repeat (TIMEOUT - 1) tick();
        chk("mwait_c8_no_halt", halt, 0);
        tick();
        chk("mwait_tmo_halt", halt, 1);
        chk("mwait_tmo_code", halt_code, 2'b11);
        chk("mwait_tmo_cnt",  retired_cnt, 0);

        // response in the 8th MWAIT cycle wins
        do_reset();
        do_fetch(c_lw);
        tick();
        lsu_req_ready = 1'b1;
        tick();
        lsu_req_ready = 1'b0;
        repeat (TIMEOUT - 1) tick();
        lsu_rsp_valid = 1'b1;
        tick();
        lsu_rsp_valid = 1'b0;
        chk("late_rsp_no_halt", halt, 0);
        chk("late_rsp_rf_we",   rf_we, 1);
        chk("late_rsp_pc_we",   pc_we, 1);
        tick();
        chk("late_rsp_cnt",   retired_cnt, 1);
        chk("late_rsp_fetch", ifu_req_valid, 1);

        // asynchronous reset during MWAIT
        do_fetch(c_lw);
        tick();
        lsu_req_ready = 1'b1;
        tick();
        lsu_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_mwait_cnt",   retired_cnt, 0);
        chk("arst_mwait_instq", inst_q, 0);
        chk("arst_mwait_lsu",   lsu_req_valid, 0);
        chk("arst_mwait_ifu",   ifu_req_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_mwait_restart", ifu_req_valid, 1);

        // IFU response withheld: halt after 8 IWAIT cycles
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        repeat (TIMEOUT - 1) tick();
        chk("iwait_c8_no_halt", halt, 0);
        tick();
        chk("iwait_tmo_halt", halt, 1);
        chk("iwait_tmo_code", halt_code, 2'b11);

        // retired counter wraps at 2^CNT_W
        do_reset();
        repeat (15) do_addi();
        chk("wrap_cnt_15", retired_cnt, 15);
        do_addi();
        chk("wrap_cnt_0", retired_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_npc_seq_ctrl
`default_nettype wire
